// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment / LED scan blocks.
// Digit k of a display word lives in nibble k; digit 0 is the rightmost.
package disp_pkg;

    localparam int DIGITS = 4;
    localparam int SEL_W  = 2;
    localparam int NIB_W  = 4;
    localparam int WORD_W = DIGITS * NIB_W;

    // Anodes are active-low, so all ones means every digit dark.
    localparam logic [DIGITS-1:0] AN_ALL_OFF = 4'b1111;

    // Digit-to-nibble mapping: LSB position of each digit in the display word.
    localparam int NIB_LSB_D0 = 0 * NIB_W;
    localparam int NIB_LSB_D1 = 1 * NIB_W;
    localparam int NIB_LSB_D2 = 2 * NIB_W;
    localparam int NIB_LSB_D3 = 3 * NIB_W;

    // Select value of the last digit in a frame.
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

endpackage

// File: rtl/scan_prescaler.sv
// Free-running scan prescaler: wraps every 2^DIV_WIDTH cycles and flags
// the final count of each period with tick. Shared by the display scanners.
module scan_prescaler #(
    parameter int DIV_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [DIV_WIDTH-1:0] count,
    output logic                 tick
);

    // Up-counter that wraps naturally at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state always uses <= so every register samples pre-edge values.
        if (!rst_n) count <= '0;
        else        count <= count + DIV_WIDTH'(1);
    end

    assign tick = &count;

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit seven-segment scan controller for the game HUD.
// Latches a display word, presents its nibbles to the digit mux, scans the
// select, and drives active-low anodes with a dead time after each digit
// change. New words only take effect at frame end, so a scan never tears.
// Optional macro DISP_LEADING_ZERO_BLANK_EN: also darken leading zero digits
// 3..1 of the committed word (digit 0 always stays lit).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV_WIDTH   = 17,
    parameter int DEAD_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data_in,
    input  logic [DIGITS-1:0] blank_in,
    output logic [SEL_W-1:0]  sel,
    output logic [NIB_W-1:0]  d0,
    output logic [NIB_W-1:0]  d1,
    output logic [NIB_W-1:0]  d2,
    output logic [NIB_W-1:0]  d3,
    output logic [DIGITS-1:0] an,
    output logic              pending
);

    localparam logic [DIV_WIDTH-1:0] DEAD_CNT = DIV_WIDTH'(DEAD_CYCLES);

    logic [DIV_WIDTH-1:0] count;
    logic                 tick;
    logic                 frame_end;
    logic [WORD_W-1:0]    word_q;
    logic [WORD_W-1:0]    buf_q;
    logic [DIGITS-1:0]    lz_mask;
    logic [DIGITS-1:0]    an_next;

    scan_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .tick  (tick)
    );

    assign frame_end = tick && (sel == SEL_LAST);

    // Digit select steps once per prescaler period and wraps 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sel <= '0;
        else if (tick) sel <= sel + SEL_W'(1);
    end

    // Pending buffer and committed word; the word only changes at frame end,
    // and a load on the frame-end cycle goes straight to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer is reset as well, so a word discarded by reset can never resurface.
        if (!rst_n) begin
            word_q  <= '0;
            buf_q   <= '0;
            pending <= 1'b0;
        end else if (frame_end) begin
            if (load)         word_q <= data_in;
            else if (pending) word_q <= buf_q;
            pending <= 1'b0;
        end else if (load) begin
            buf_q   <= data_in;
            pending <= 1'b1;
        end
    end

    assign d0 = word_q[NIB_LSB_D0 +: NIB_W];
    assign d1 = word_q[NIB_LSB_D1 +: NIB_W];
    assign d2 = word_q[NIB_LSB_D2 +: NIB_W];
    assign d3 = word_q[NIB_LSB_D3 +: NIB_W];

`ifdef DISP_LEADING_ZERO_BLANK_EN
    // Digit k (k >= 1) is a leading zero when it and every digit above it are 0.
    logic z1, z2, z3;
    assign z1 = (d1 == '0);
    assign z2 = (d2 == '0);
    assign z3 = (d3 == '0);
    assign lz_mask = {z3, z3 & z2, z3 & z2 & z1, 1'b0};
`else
    assign lz_mask = '0;
`endif

    // Anode pattern: dark during dead time, else the selected digit, then masks.
    always_comb begin
        // NOTE: default assigned first so every path drives an_next and no latch is inferred.
        an_next = AN_ALL_OFF;
        if (count >= DEAD_CNT) an_next[sel] = 1'b0;
        an_next = an_next | blank_in | lz_mask;
    end

    // Anodes are registered: a uniform one-cycle lag behind count and sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) an <= AN_ALL_OFF;
        else        an <= an_next;
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl with DIV_WIDTH=4 (16-cycle digit) and DEAD_CYCLES=2.
// The reference model tracks time since reset and the last word loaded; the
// expected scan state is plain arithmetic on that time.
module tb_disp_scan_ctrl;

    localparam int DIV_WIDTH   = 4;
    localparam int DEAD_CYCLES = 2;
    localparam int P           = 1 << DIV_WIDTH;
    localparam int FRAME       = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  blank_in = '0;
    logic [1:0]  sel;
    logic [3:0]  d0, d1, d2, d3;
    logic [3:0]  an;
    logic        pending;

    int n_cmp  = 0;
    int n_fail = 0;

    disp_scan_ctrl #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data_in  (data_in),
        .blank_in (blank_in),
        .sel      (sel),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .an       (an),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_t;       // clock edges since reset release
    logic [15:0] m_shown;   // word on the display
    logic [15:0] m_latest;  // most recent word loaded since the last frame end
    bit          m_new;     // a word is waiting for the next frame end
    logic [3:0]  m_an;      // expected anodes (one-cycle registered view)

    function automatic logic [3:0] exp_an(int t, logic [3:0] blank, logic [15:0] word);
        logic [3:0] a;
        int         pos;
        int         digit;
        int         top;
        pos   = t % P;
        digit = (t / P) % 4;
        a     = 4'b1111;
        if (pos >= DEAD_CYCLES) a[digit] = 1'b0;
        a = a | blank;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        top = 0;
        for (int k = 0; k < 4; k++) if (((word >> (4 * k)) & 16'hF) != 0) top = k;
        for (int k = 1; k < 4; k++) if (k > top) a[k] = 1'b1;
`else
        top = 0;
`endif
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t      <= 0;
            m_shown  <= '0;
            m_latest <= '0;
            m_new    <= 1'b0;
            m_an     <= 4'b1111;
        end else begin
            m_an <= exp_an(m_t, blank_in, m_shown);
            m_t  <= m_t + 1;
            if ((m_t % FRAME) == FRAME - 1) begin
                m_shown <= load ? data_in : (m_new ? m_latest : m_shown);
                m_new   <= 1'b0;
            end else if (load) begin
                m_latest <= data_in;
                m_new    <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("sel",     32'(sel), 32'((m_t / P) % 4));
        check("word",    32'({d3, d2, d1, d0}), 32'(m_shown));
        check("an",      32'(an), 32'(m_an));
        check("pending", 32'(pending), 32'(m_new));
    end

    // ---------------- stimulus helpers ----------------
    // Wait (at negedges) until the scan sits at digit s, prescaler c.
    task automatic goto(input int s, input int c);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            @(negedge clk);
            hit = ((m_t % P) == c) && (((m_t / P) % 4) == s);
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL goto_bound: scan position %0d/%0d not reached in budget", s, c);
        end
    endtask

    task automatic pulse_load(input logic [15:0] w);
        load    = 1'b1;
        data_in = w;
        @(negedge clk);
        load    = 1'b0;
    endtask

    bit seen [4];

    initial begin
        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_sel",     32'(sel), 32'h0);
        check("rst_an",      32'(an), 32'hF);
        check("rst_word",    32'({d3, d2, d1, d0}), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        rst_n = 1'b1;

        // Free scan: after 5 edges prescaler=5, an shows digit 0.
        repeat (5) @(negedge clk);
        check("scan5_an",  32'(an), 32'hE);
        check("scan5_sel", 32'(sel), 32'h0);
        repeat (11) @(negedge clk);   // 16 edges: first select step
        check("scan16_sel", 32'(sel), 32'h1);
        check("scan16_an",  32'(an), 32'hE);
        @(negedge clk);               // dead time begins for digit 1
        check("scan17_an",  32'(an), 32'hF);
        repeat (2) @(negedge clk);
        check("scan19_an",  32'(an), 32'hD);

        // Load during digit 1: held pending until the wrap.
        goto(1, 5);
        pulse_load(16'h1234);
        check("p1234_pending", 32'(pending), 32'h1);
        check("p1234_word",    32'({d3, d2, d1, d0}), 32'h0);
        goto(3, 15);
        check("p1234_late_word", 32'({d3, d2, d1, d0}), 32'h0);
        @(negedge clk);
        check("c1234_word",    32'({d3, d2, d1, d0}), 32'h1234);
        check("c1234_pending", 32'(pending), 32'h0);
        check("c1234_sel",     32'(sel), 32'h0);

        // Two loads in one frame: last write wins.
        goto(0, 3);
        pulse_load(16'hAAAA);
        goto(2, 7);
        pulse_load(16'h5678);
        goto(3, 15);
        check("ow_hold_word", 32'({d3, d2, d1, d0}), 32'h1234);
        @(negedge clk);
        check("ow_word", 32'({d3, d2, d1, d0}), 32'h5678);

        // Load on the exact frame-end cycle: direct commit.
        goto(3, 15);
        pulse_load(16'hBEEF);
        check("beef_word",    32'({d3, d2, d1, d0}), 32'hBEEF);
        check("beef_sel",     32'(sel), 32'h0);
        check("beef_pending", 32'(pending), 32'h0);

        // Per-digit blank: digit 2 stays dark for a whole frame.
        blank_in = 4'b0100;
        @(negedge clk);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check("blank_an2", 32'(an[2]), 32'h1);
        end
        blank_in = 4'b0000;

        // Reset while a word is pending: the word is discarded.
        goto(2, 3);
        pulse_load(16'h1111);
        check("mid_pending", 32'(pending), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pending", 32'(pending), 32'h0);
        check("mid_rst_word",    32'({d3, d2, d1, d0}), 32'h0);
        check("mid_rst_an",      32'(an), 32'hF);
        check("mid_rst_sel",     32'(sel), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 8) @(negedge clk);
        check("post_rst_word",    32'({d3, d2, d1, d0}), 32'h0);
        check("post_rst_pending", 32'(pending), 32'h0);

        // Word 0x0040: which digits ever light during a full frame.
        goto(0, 0);
        pulse_load(16'h0040);
        goto(3, 15);
        @(negedge clk);
        check("lz_word", 32'({d3, d2, d1, d0}), 32'h0040);
        for (int k = 0; k < 4; k++) seen[k] = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (an[k] == 1'b0) seen[k] = 1'b1;
        end
`ifdef DISP_LEADING_ZERO_BLANK_EN
        check("lz_seen3", 32'(seen[3]), 32'h0);
        check("lz_seen2", 32'(seen[2]), 32'h0);
`else
        check("lz_seen3", 32'(seen[3]), 32'h1);
        check("lz_seen2", 32'(seen[2]), 32'h1);
`endif
        check("lz_seen1", 32'(seen[1]), 32'h1);
        check("lz_seen0", 32'(seen[0]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
